// File: rtl/cntr_seq_ctrl.sv
// Sequencer that drives an enable-less up/down counter through P passes of start..end, one command at a time.
// done/aborted pulse one cycle after the last step or abort; cmd_ready is high only in IDLE (no queuing).
module cntr_seq_ctrl #(
    parameter int n  = 4,
    parameter int RW = 4
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          cmd_valid,
    output logic          cmd_ready,
    input  logic [n-1:0]  cmd_start,
    input  logic [n-1:0]  cmd_end,
    input  logic          cmd_up,
    input  logic [RW-1:0] cmd_reps,
    input  logic          abort,
    input  logic [n-1:0]  cnt_z,
    output logic [n-1:0]  cnt_d_in,
    output logic          cnt_ld,
    output logic          cnt_up,
    output logic          busy,
    output logic          done,
    output logic          aborted
);

    localparam logic [2:0] S_IDLE = 3'd0;
    localparam logic [2:0] S_LOAD = 3'd1;
    localparam logic [2:0] S_RUN  = 3'd2;
    localparam logic [2:0] S_DONE = 3'd3;
    localparam logic [2:0] S_ABRT = 3'd4;

    logic [2:0]    r_state;
    logic [2:0]    w_next;
    logic [n-1:0]  r_hold;
    logic [n-1:0]  r_start;
    logic [n-1:0]  r_end;
    logic          r_dir;
    logic [RW-1:0] r_reps;
    logic          w_match;
    logic          w_abort;
    logic          w_accept;

    assign w_match   = (cnt_z == r_end);
    assign w_abort   = abort && ((r_state == S_LOAD) || (r_state == S_RUN));
    assign w_accept  = cmd_valid && cmd_ready;
    assign cmd_ready = (r_state == S_IDLE) && rst;
    assign busy      = (r_state == S_LOAD) || (r_state == S_RUN);
    assign done      = (r_state == S_DONE);
    assign aborted   = (r_state == S_ABRT);
    assign cnt_up    = r_dir;

    // The counter has no enable, so every state except a counting RUN cycle reloads it.
    always_comb begin
        w_next   = r_state;
        cnt_ld   = 1'b1;
        cnt_d_in = r_hold;
        case (r_state)
            S_IDLE: begin
                cnt_d_in = r_hold;
                if (w_accept) w_next = S_LOAD;
            end
            S_LOAD: begin
                if (w_abort) begin
                    cnt_d_in = cnt_z;
                    w_next   = S_ABRT;
                end else begin
                    cnt_d_in = r_start;
                    w_next   = S_RUN;
                end
            end
            S_RUN: begin
                if (w_abort) begin
                    cnt_d_in = cnt_z;
                    w_next   = S_ABRT;
                end else if (w_match) begin
                    if (r_reps != '0) begin
                        cnt_d_in = r_start;
                    end else begin
                        cnt_d_in = r_end;
                        w_next   = S_DONE;
                    end
                end else begin
                    cnt_ld   = 1'b0;
                    cnt_d_in = r_start;
                end
            end
            S_DONE: begin
                cnt_d_in = r_end;
                w_next   = S_IDLE;
            end
            S_ABRT: begin
                cnt_d_in = r_hold;
                w_next   = S_IDLE;
            end
            default: begin
                w_next = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state <= S_IDLE;
            r_hold  <= '0;
            r_start <= '0;
            r_end   <= '0;
            r_dir   <= 1'b1;
            r_reps  <= '0;
        end else begin
            r_state <= w_next;
            if ((r_state == S_IDLE) && w_accept) begin
                r_start <= cmd_start;
                r_end   <= cmd_end;
                r_dir   <= cmd_up;
                r_reps  <= cmd_reps;
            end
            if ((r_state == S_RUN) && !w_abort && w_match && (r_reps != '0)) begin
                r_reps <= r_reps - RW'(1);
            end
            // Parked value is what IDLE keeps reloading until the next command.
            if (w_abort) begin
                r_hold <= cnt_z;
            end else if (r_state == S_DONE) begin
                r_hold <= r_end;
            end
        end
    end

endmodule

// Universal up/down counter with synchronous load and no enable; wraps modulo 2^n.
// One-cycle latency from i_ld/i_d to o_z; always advances, no backpressure.
module univ_cntr #(
    parameter int n = 4
) (
    input  logic         i_clk,
    input  logic         i_ld,
    input  logic         i_up,
    input  logic [n-1:0] i_d,
    output logic [n-1:0] o_z
);

    logic [n-1:0] r_z;

    always_ff @(posedge i_clk) begin
        if (i_ld) begin
            r_z <= i_d;
        end else if (i_up) begin
            r_z <= r_z + n'(1);
        end else begin
            r_z <= r_z - n'(1);
        end
    end

    assign o_z = r_z;

endmodule

// File: tb/tb_cntr_seq_ctrl.sv
// Scoreboard bench: cntr_seq_ctrl driving univ_cntr, checked per cycle against a trace built from pass arithmetic.
module tb_cntr_seq_ctrl;
    localparam int N    = 4;
    localparam int RW   = 4;
    localparam int MASK = (1 << N) - 1;

    logic          clk = 1'b0;
    logic          rst;
    logic          cmd_valid;
    logic          cmd_ready;
    logic [N-1:0]  cmd_start;
    logic [N-1:0]  cmd_end;
    logic          cmd_up;
    logic [RW-1:0] cmd_reps;
    logic          abort;
    logic [N-1:0]  cnt_z;
    logic [N-1:0]  cnt_d_in;
    logic          cnt_ld;
    logic          cnt_up;
    logic          busy;
    logic          done;
    logic          aborted;

    always #5 clk = ~clk;

    cntr_seq_ctrl #(.n(N), .RW(RW)) dut (
        .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_start(cmd_start), .cmd_end(cmd_end), .cmd_up(cmd_up), .cmd_reps(cmd_reps),
        .abort(abort), .cnt_z(cnt_z), .cnt_d_in(cnt_d_in), .cnt_ld(cnt_ld),
        .cnt_up(cnt_up), .busy(busy), .done(done), .aborted(aborted)
    );

    univ_cntr #(.n(N)) u_cnt (
        .i_clk(clk), .i_ld(cnt_ld), .i_up(cnt_up), .i_d(cnt_d_in), .o_z(cnt_z)
    );

    typedef struct {
        bit chk;
        bit z_c;
        int z;
        bit ld_c;
        bit ld;
        bit din_c;
        int din;
        bit busy;
        bit ready;
        bit done;
        bit ab;
        int id;
        int cyc;
    } exp_t;

    exp_t q[$];
    exp_t m_e;
    int   n_cmp = 0;
    int   n_bad = 0;
    int   parked = 0;
    int   cmd_id = 0;

    task automatic chk(input string name, input int id, input int cyc, input int act, input int want);
        n_cmp++;
        if (act != want) begin
            n_bad++;
            $display("FAIL %s cmd%0d cyc%0d: got %0d want %0d", name, id, cyc, act, want);
        end
    endtask

    // Monitor: one expected record per cycle, popped mid-cycle.
    always @(negedge clk) begin
        if (q.size() > 0) begin
            m_e = q.pop_front();
            if (m_e.chk) begin
                chk("busy", m_e.id, m_e.cyc, int'(busy), int'(m_e.busy));
                chk("cmd_ready", m_e.id, m_e.cyc, int'(cmd_ready), int'(m_e.ready));
                chk("done", m_e.id, m_e.cyc, int'(done), int'(m_e.done));
                chk("aborted", m_e.id, m_e.cyc, int'(aborted), int'(m_e.ab));
                if (m_e.z_c)   chk("cnt_z", m_e.id, m_e.cyc, int'(cnt_z), m_e.z);
                if (m_e.ld_c)  chk("cnt_ld", m_e.id, m_e.cyc, int'(cnt_ld), int'(m_e.ld));
                if (m_e.din_c) chk("cnt_d_in", m_e.id, m_e.cyc, int'(cnt_d_in), m_e.din);
            end
        end
    end

    function automatic exp_t mk(input int id, input int cyc, input bit b, input bit r,
                                input bit d, input bit a);
        exp_t x;
        x = '{default: 0};
        x.chk = 1'b1; x.id = id; x.cyc = cyc;
        x.busy = b; x.ready = r; x.done = d; x.ab = a;
        return x;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_cycles(input int cnt, input bit noise);
        exp_t x;
        for (int i = 0; i < cnt; i++) begin
            rst = 1'b1; cmd_valid = 1'b0;
            abort = noise ? 1'($urandom_range(0, 1)) : 1'b0;
            x = mk(cmd_id, -1, 0, 1, 0, 0);
            x.z_c = 1; x.z = parked; x.ld_c = 1; x.ld = 1; x.din_c = 1; x.din = parked;
            q.push_back(x);
            step();
        end
    endtask

    // Expected trace per command: cycle 0 handshake, cycle 1 load, then P passes of k+1 run cycles.
    task automatic run_cmd(input int s, input int e, input bit up, input int reps,
                           input int ab_cyc, input int rst_cyc, input bit noise);
        int k, p, d, last, p0, off, pass, zc, zab;
        exp_t x;
        cmd_id++;
        k    = up ? ((e - s) & MASK) : ((s - e) & MASK);
        p    = reps + 1;
        d    = 2 + p * (k + 1);
        last = (ab_cyc >= 0) ? ab_cyc + 1 : ((rst_cyc >= 0) ? rst_cyc + 1 : d);
        p0   = parked;
        zab  = p0;
        for (int c = 0; c <= last; c++) begin
            rst = !((rst_cyc >= 0) && ((c == rst_cyc) || (c == rst_cyc + 1)));
            abort = 1'b0;
            if (c == 0) begin
                cmd_valid = 1'b1; cmd_start = N'(s); cmd_end = N'(e);
                cmd_up = up; cmd_reps = RW'(reps);
            end else begin
                cmd_valid = noise ? 1'($urandom_range(0, 1)) : 1'b0;
                cmd_start = N'($urandom); cmd_end = N'($urandom);
                cmd_up = 1'($urandom); cmd_reps = RW'($urandom);
            end
            if (c == ab_cyc) abort = 1'b1;
            else if (noise && rst && (c == 0 || c >= d || (ab_cyc >= 0 && c > ab_cyc)))
                abort = 1'($urandom_range(0, 1));
            off  = (c >= 2) ? (c - 2) % (k + 1) : 0;
            pass = (c >= 2) ? (c - 2) / (k + 1) : 0;
            zc   = (c >= 2) ? ((up ? s + off : s - off) & MASK) : p0;
            if (c == ab_cyc) zab = zc;
            if ((rst_cyc >= 0) && (c == rst_cyc)) begin
                x = '{default: 0};
                x.id = cmd_id; x.cyc = c;
            end else if ((rst_cyc >= 0) && (c == rst_cyc + 1)) begin
                x = mk(cmd_id, c, 0, 0, 0, 0);
                x.ld_c = 1; x.ld = 1; x.din_c = 1; x.din = 0;
                parked = 0;
            end else if ((ab_cyc >= 0) && (c == ab_cyc + 1)) begin
                x = mk(cmd_id, c, 0, 0, 0, 1);
                x.z_c = 1; x.z = zab; x.ld_c = 1; x.ld = 1; x.din_c = 1; x.din = zab;
                parked = zab;
            end else if (c == 0) begin
                x = mk(cmd_id, c, 0, 1, 0, 0);
                x.z_c = 1; x.z = p0; x.ld_c = 1; x.ld = 1; x.din_c = 1; x.din = p0;
            end else if (c == 1) begin
                x = mk(cmd_id, c, 1, 0, 0, 0);
                x.z_c = 1; x.z = p0; x.ld_c = 1; x.ld = 1;
                x.din_c = 1; x.din = (c == ab_cyc) ? p0 : s;
            end else if (c < d) begin
                x = mk(cmd_id, c, 1, 0, 0, 0);
                x.z_c = 1; x.z = zc; x.ld_c = 1;
                x.ld = (c == ab_cyc) || (off == k);
                x.din_c = x.ld;
                x.din = (c == ab_cyc) ? zc : ((pass < p - 1) ? s : e);
            end else begin
                x = mk(cmd_id, c, 0, 0, 1, 0);
                x.z_c = 1; x.z = e; x.ld_c = 1; x.ld = 1; x.din_c = 1; x.din = e;
                parked = e;
            end
            q.push_back(x);
            step();
        end
        cmd_valid = 1'b0; abort = 1'b0; rst = 1'b1;
    endtask

    initial begin
        int s, e, reps, k, d, mode, ab, rc;
        bit up;
        exp_t x;
        rst = 1'b0; cmd_valid = 1'b0; abort = 1'b0;
        cmd_start = '0; cmd_end = '0; cmd_up = 1'b0; cmd_reps = '0;
        step();
        x = mk(0, 0, 0, 0, 0, 0);
        x.ld_c = 1; x.ld = 1; x.din_c = 1; x.din = 0;
        q.push_back(x);
        step();
        x.cyc = 1; x.z_c = 1; x.z = 0;
        q.push_back(x);
        step();
        parked = 0;
        idle_cycles(3, 1);

        run_cmd(3, 7, 1, 0, -1, -1, 0);   idle_cycles(2, 0);
        run_cmd(2, 14, 0, 1, -1, -1, 0);  idle_cycles(2, 0);
        run_cmd(5, 5, 1, 2, -1, -1, 0);   idle_cycles(2, 0);
        run_cmd(0, 15, 1, 0, 8, -1, 1);   idle_cycles(2, 1);
        run_cmd(4, 9, 1, 1, 13, -1, 1);   idle_cycles(2, 1);
        run_cmd(1, 10, 1, 0, -1, 5, 1);   idle_cycles(2, 1);

        for (int i = 0; i < 40; i++) begin
            s    = int'($urandom_range(0, MASK));
            e    = int'($urandom_range(0, MASK));
            up   = 1'($urandom_range(0, 1));
            reps = int'($urandom_range(0, 2));
            k    = up ? ((e - s) & MASK) : ((s - e) & MASK);
            d    = 2 + (reps + 1) * (k + 1);
            mode = int'($urandom_range(0, 8));
            ab   = (mode == 6 || mode == 7) ? int'($urandom_range(1, d - 1)) : -1;
            rc   = (mode == 8) ? int'($urandom_range(1, d - 1)) : -1;
            run_cmd(s, e, up, reps, ab, rc, 1);
            idle_cycles(int'($urandom_range(1, 3)), 1);
        end

        @(negedge clk);
        @(negedge clk);
        chk("queue_drained", cmd_id, -1, q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/cntr_seq_ctrl.md
CNTR_SEQ_CTRL -- requirements
Module: cntr_seq_ctrl

Interface
REQ-001 Parameter n, default 4: counter data width.
REQ-002 Parameter RW, default 4: repeat-count width.
REQ-003 clk  input  1  single clock; all state SHALL update on the rising edge.
REQ-004 rst  input  1  reset, synchronous, active-low.
REQ-005 cmd_valid  input  1  command offered.
REQ-006 cmd_ready  output  1  controller can accept a command.
REQ-007 cmd_start  input  n  first count value of each pass.
REQ-008 cmd_end  input  n  terminal count value of each pass.
REQ-009 cmd_up  input  1  direction: 1 = up, 0 = down.
REQ-010 cmd_reps  input  RW  extra passes; total passes P = cmd_reps+1.
REQ-011 abort  input  1  stop the active command.
REQ-012 cnt_z  input  n  current counter value.
REQ-013 cnt_d_in  output  n  counter load value.
REQ-014 cnt_ld  output  1  counter load strobe.
REQ-015 cnt_up  output  1  counter direction.
REQ-016 busy  output  1  command in progress (LOAD or RUN).
REQ-017 done  output  1  one-cycle pulse: command completed normally.
REQ-018 aborted  output  1  one-cycle pulse: command terminated by abort.

Function
REQ-019 Driven counter contract: each edge, cnt_ld=1 -> z<=cnt_d_in; otherwise z<=z+1 (cnt_up=1) or z-1 (cnt_up=0), modulo 2^n. The counter has no enable, so the controller SHALL hold it by continuous load.
REQ-020 States: IDLE, LOAD, RUN, DONE, ABRT. All outputs SHALL be decoded from registered state plus the cnt_z compare in RUN.
REQ-021 IDLE: cmd_ready=rst; cnt_ld=1; cnt_d_in=hold_r (the last parked value).
REQ-022 IDLE: cmd_valid&&cmd_ready latches start_r, end_r, dir_r and reps_left=cmd_reps, then goes to LOAD. This handshake cycle is cycle 0.
REQ-023 LOAD (cycle 1): cnt_ld=1, cnt_d_in=start_r; then goes to RUN, so cnt_z=start_r in cycle 2.
REQ-024 RUN, cnt_z!=end_r: cnt_ld=0, cnt_up=dir_r.
REQ-025 RUN, cnt_z==end_r and reps_left!=0: cnt_ld=1, cnt_d_in=start_r, decrement reps_left, stay in RUN.
REQ-026 RUN, cnt_z==end_r and reps_left==0: cnt_ld=1, cnt_d_in=end_r, go to DONE.
REQ-027 DONE: done=1, cnt_ld=1, cnt_d_in=end_r, hold_r<=end_r; next state IDLE.
REQ-028 Step count k = (end_r-start_r) mod 2^n when up, (start_r-end_r) mod 2^n when down. Wrap-around is legal.
REQ-029 Each pass SHALL last k+1 RUN cycles. done SHALL assert in cycle 2+P*(k+1).
REQ-030 start_r==end_r gives k=0: each pass is one cycle and cnt_z stays constant.
REQ-031 abort in LOAD or RUN: cnt_ld=1, cnt_d_in=cnt_z, hold_r<=cnt_z, go to ABRT.
REQ-032 ABRT: aborted=1, cnt_ld=1, cnt_d_in=hold_r; next state IDLE. The counter value SHALL freeze at the value seen in the abort cycle.
REQ-033 abort has priority over an end match in the same cycle: no done pulse.
REQ-034 abort in IDLE, DONE or ABRT SHALL be ignored.
REQ-035 cmd_ready=0 in every non-IDLE state; cmd_valid there SHALL have no effect. No command queuing.
REQ-036 busy=1 exactly in LOAD and RUN.
REQ-037 cnt_up=dir_r in all states.

Reset
REQ-038 rst==0 at a rising edge: state<=IDLE; hold_r, start_r, end_r, reps_left<=0; dir_r<=1.
REQ-039 While rst==0: cmd_ready=0, done=0, aborted=0, busy=0 after the first reset edge.
REQ-040 After the first reset edge: cnt_ld=1 and cnt_d_in=0, so the counter is parked at 0.
REQ-041 Reset asserted mid-command SHALL discard the command with no done or aborted pulse. The counter is reloaded to 0.

Verification
REQ-042 The bench SHALL pair cntr_seq_ctrl with univ_cntr (n=4) and check every cycle against a reference model.
REQ-043 Reset: rst=0 for 2 cycles -> cnt_ld=1, cnt_d_in=0, cmd_ready=0; after rst=1, cmd_ready=1 and cnt_z stays 0.
REQ-044 Up pass: start=3, end=7, up=1, reps=0 -> cnt_z 3,4,5,6,7 in cycles 2-6; done in cycle 7; cnt_z then holds 7.
REQ-045 Down with wrap: start=2, end=14, up=0, reps=1 -> cnt_z 2,1,0,15,14 twice; done in cycle 12; cnt_z holds 14.
REQ-046 Degenerate: start=end=5, reps=2 -> cnt_z=5 throughout; done in cycle 5; busy high in cycles 1-4 only.
REQ-047 Abort: start=0, end=15, up=1, abort when cnt_z=6 -> aborted next cycle, no done, cnt_z frozen at 6, cmd_ready=1 after.
REQ-047 also requires that cmd_valid pulses offered while busy are not accepted.
REQ-048 Collision: abort in the same cycle cnt_z==end_r on the last pass -> aborted=1 and done never asserted.
REQ-048 also covers rst=0 mid-RUN -> no pulses, and cnt_z=0 after reset.
